// File: rtl/custom_axi_ip_pkg.sv
// Shared types and constants for the custom_axi_ip request arbiter.
package custom_axi_ip_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE,
        ARB_ISSUE,
        ARB_WAIT,
        ARB_RESP
    } arb_state_e;

    localparam logic [7:0] ERR_CNT_MAX = 8'hFF;

endpackage

// File: rtl/custom_axi_ip_rr_pick.sv
// Combinational round-robin selector: first set request at or above ptr_i, with wrap.
module custom_axi_ip_rr_pick #(
    parameter int unsigned NUM_REQ = 4
) (
    input  logic [NUM_REQ-1:0]         req_i,
    input  logic [$clog2(NUM_REQ)-1:0] ptr_i,
    output logic                       any_o,
    output logic [$clog2(NUM_REQ)-1:0] winner_o
);

    localparam int unsigned IW = $clog2(NUM_REQ);

    int unsigned idx;

    always_comb begin
        any_o    = 1'b0;
        winner_o = '0;
        idx      = 0;
        for (int unsigned off = 0; off < NUM_REQ; off++) begin
            idx = (32'(ptr_i) + off) % NUM_REQ;
            if (!any_o && req_i[IW'(idx)]) begin
                any_o    = 1'b1;
                winner_o = IW'(idx);
            end
        end
    end

endmodule

// File: rtl/custom_axi_ip_arbiter.sv
// Round-robin arbiter sharing one custom_axi_ip datapath between NUM_REQ requesters,
// with completion timeout and a per-requester valid/ready response channel.
module custom_axi_ip_arbiter
    import custom_axi_ip_pkg::*;
#(
    parameter int unsigned NUM_REQ    = 4,
    parameter int unsigned DATA_WIDTH = 16,
    parameter int unsigned TIMEOUT    = 64
) (
    input  logic                          clk_i,
    input  logic                          rst_ni,
    input  logic [NUM_REQ-1:0]            req_valid_i,
    output logic [NUM_REQ-1:0]            req_ready_o,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data_i,
    output logic [NUM_REQ-1:0]            rsp_valid_o,
    input  logic [NUM_REQ-1:0]            rsp_ready_i,
    output logic [DATA_WIDTH-1:0]         rsp_data_o,
    output logic                          rsp_err_o,
    output logic [DATA_WIDTH-1:0]         ip_din_o,
    output logic                          ip_enable_o,
    input  logic [DATA_WIDTH-1:0]         ip_dout_i,
    input  logic                          ip_done_i,
    output logic                          busy_o,
    output logic [$clog2(NUM_REQ)-1:0]    grant_id_o,
    output logic [7:0]                    err_cnt_o
);

    localparam int unsigned IW = $clog2(NUM_REQ);
    localparam int unsigned CW = $clog2(TIMEOUT);
    localparam logic [CW-1:0] WAIT_LAST = CW'(TIMEOUT - 1);
    localparam logic [IW-1:0] LAST_REQ  = IW'(NUM_REQ - 1);

    arb_state_e            state_q, state_d;
    logic [IW-1:0]         rr_ptr_q, rr_ptr_d;
    logic [IW-1:0]         grant_q, grant_d;
    logic [DATA_WIDTH-1:0] din_q, din_d;
    logic [DATA_WIDTH-1:0] rsp_data_q, rsp_data_d;
    logic                  rsp_err_q, rsp_err_d;
    logic [CW-1:0]         wait_q, wait_d;
    logic [7:0]            err_cnt_q, err_cnt_d;

    logic                  any_valid;
    logic [IW-1:0]         winner;
    logic [DATA_WIDTH-1:0] req_data_arr [NUM_REQ];

    for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
        assign req_data_arr[g] = req_data_i[g*DATA_WIDTH +: DATA_WIDTH];
    end

    custom_axi_ip_rr_pick #(
        .NUM_REQ(NUM_REQ)
    ) u_pick (
        .req_i   (req_valid_i),
        .ptr_i   (rr_ptr_q),
        .any_o   (any_valid),
        .winner_o(winner)
    );

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q    <= ARB_IDLE;
            rr_ptr_q   <= '0;
            grant_q    <= '0;
            din_q      <= '0;
            rsp_data_q <= '0;
            rsp_err_q  <= 1'b0;
            wait_q     <= '0;
            err_cnt_q  <= '0;
        end else begin
            state_q    <= state_d;
            rr_ptr_q   <= rr_ptr_d;
            grant_q    <= grant_d;
            din_q      <= din_d;
            rsp_data_q <= rsp_data_d;
            rsp_err_q  <= rsp_err_d;
            wait_q     <= wait_d;
            err_cnt_q  <= err_cnt_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        rr_ptr_d    = rr_ptr_q;
        grant_d     = grant_q;
        din_d       = din_q;
        rsp_data_d  = rsp_data_q;
        rsp_err_d   = rsp_err_q;
        wait_d      = wait_q;
        err_cnt_d   = err_cnt_q;
        req_ready_o = '0;
        rsp_valid_o = '0;
        ip_enable_o = 1'b0;

        unique case (state_q)
            ARB_IDLE: begin
                // Ready is only offered to the winner, so any_valid implies a handshake.
                if (any_valid) begin
                    req_ready_o[winner] = 1'b1;
                    din_d               = req_data_arr[winner];
                    grant_d             = winner;
                    state_d             = ARB_ISSUE;
                end
            end
            ARB_ISSUE: begin
                ip_enable_o = 1'b1;
                wait_d      = '0;
                state_d     = ARB_WAIT;
            end
            ARB_WAIT: begin
                if (ip_done_i) begin
                    rsp_data_d = ip_dout_i;
                    rsp_err_d  = 1'b0;
                    state_d    = ARB_RESP;
                end else if (wait_q == WAIT_LAST) begin
                    rsp_data_d = '0;
                    rsp_err_d  = 1'b1;
                    if (err_cnt_q != ERR_CNT_MAX) begin
                        err_cnt_d = err_cnt_q + 8'd1;
                    end
                    state_d = ARB_RESP;
                end else begin
                    wait_d = wait_q + 1'b1;
                end
            end
            ARB_RESP: begin
                rsp_valid_o[grant_q] = 1'b1;
                if (rsp_ready_i[grant_q]) begin
                    rr_ptr_d = (grant_q == LAST_REQ) ? '0 : grant_q + 1'b1;
                    state_d  = ARB_IDLE;
                end
            end
            default: state_d = ARB_IDLE;
        endcase
    end

    assign ip_din_o   = din_q;
    assign rsp_data_o = rsp_data_q;
    assign rsp_err_o  = rsp_err_q;
    assign busy_o     = (state_q != ARB_IDLE);
    assign grant_id_o = grant_q;
    assign err_cnt_o  = err_cnt_q;

endmodule
